// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm
//   UART receiver. A frame is start(0), DATA_BITS data bits LSB-first, one
//   parity bit, then stop(1). The line is resynchronised and then sampled at
//   the centre of each bit. Received words and their error flags are
//   reported with a single-cycle o_valid pulse.
//
// Ports
//   i_clk        in   system clock, rising edge
//   i_reset      in   asynchronous active-low reset
//   i_rx         in   serial line; idles high; asynchronous to i_clk
//   o_data       out  last received word; held until the next o_valid
//   o_valid      out  1-cycle pulse; o_data and the error flags are valid
//   o_parity_err out  parity mismatch on this frame (qualified by o_valid)
//   o_frame_err  out  stop bit sampled low (qualified by o_valid)
//   o_busy       out  high in every state except IDLE
//   o_dbg_state  out  current FSM state, for observation only
//
// Handshake: o_valid is a push-only strobe with no ready. The consumer must
// capture o_data/o_parity_err/o_frame_err in the same cycle that o_valid is high.
module uart_rx_fsm #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy,
  output logic [2:0]           o_dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] MID_C  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT_C = BIT_W'(DATA_BITS - 1);
  localparam logic ODD_C = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_meta_q, rx_s_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // Half-bit check rejects glitches; restarting the counter here puts
        // every later sample at a bit centre.
        if (cnt_q == MID_C) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == LAST_BIT_C) begin
            bit_d   = '0;
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = '0;
          perr_d  = rx_s_q ^ (^shreg_q) ^ ODD_C;
          state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == LAST_C) begin
          cnt_d      = '0;
          data_d     = shreg_q;
          valid_d    = 1'b1;
          perr_out_d = perr_q;
          ferr_d     = ~rx_s_q;
          // A low stop bit means the line may stay low; BREAK stops that
          // from being mistaken for the next start bit.
          state_d    = rx_s_q ? IDLE : BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= i_rx;
      rx_s_q     <= rx_meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_out_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != IDLE);
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm with CLKS_PER_BIT=8, DATA_BITS=8, even parity.
module tb_uart_rx_fsm;

  localparam int LATENCY = 86;  // 2 + MID(3) + 10*8 + 1

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid, perr, ferr, busy;
  logic [2:0] dbg_state;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_fsm #(
    .CLKS_PER_BIT(8),
    .DATA_BITS   (8),
    .PARITY_ODD  (0)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst_n),
    .i_rx        (rx),
    .o_data      (data),
    .o_valid     (valid),
    .o_parity_err(perr),
    .o_frame_err (ferr),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  // scoreboard state: {frame_err, parity_err, data}
  logic [9:0] exp_q[$];
  int         start_q[$];
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  logic [7:0] hold_data = 8'h00;
  logic       prev_valid = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // monitor: pops the expected queue on every o_valid pulse
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_data  = 8'h00;
      prev_valid = 1'b0;
    end else begin
      if (valid) begin
        n_valid++;
        chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
        chk("valid_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          logic [9:0] e;
          int st;
          e  = exp_q.pop_front();
          st = start_q.pop_front();
          chk("data", {24'd0, data}, {24'd0, e[7:0]});
          chk("parity_err", {31'd0, perr}, {31'd0, e[8]});
          chk("frame_err", {31'd0, ferr}, {31'd0, e[9]});
          chk("latency", cyc - st, LATENCY);
          hold_data = e[7:0];
        end
      end else begin
        chk("data_hold", {24'd0, data}, {24'd0, hold_data});
        chk("perr_pulse_only", {31'd0, perr}, 32'd0);
        chk("ferr_pulse_only", {31'd0, ferr}, 32'd0);
      end
      prev_valid = valid;
    end
  end

  // driver tasks; each returns 1 time unit after a rising edge
  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic flip, input logic stop,
                            input int stop_hold);
    exp_q.push_back({~stop, flip, d});
    start_q.push_back(cyc + 1);  // first edge that sees the start bit
    drive_bit(1'b0, 8);
    for (int i = 0; i < 8; i++) drive_bit(d[i], 8);
    drive_bit((^d) ^ flip, 8);
    drive_bit(stop, stop_hold);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
    chk({tag, "_perr"}, {31'd0, perr}, 32'd0);
    chk({tag, "_ferr"}, {31'd0, ferr}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int seen;
    logic [7:0] d55;
    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    drive_bit(1'b1, 8 + $urandom_range(0, 3));

    // 1: clean 0xA5
    send_frame(8'hA5, 1'b0, 1'b1, 8);
    drive_bit(1'b1, 12);
    chk("t1_count", n_valid, 1);

    // 2: 0xA5 with wrong parity
    send_frame(8'hA5, 1'b1, 1'b1, 8);
    drive_bit(1'b1, 12);
    chk("t2_count", n_valid, 2);

    // 3: 0x3C with low stop bit and line held low, then a fresh frame
    send_frame(8'h3C, 1'b0, 1'b0, 20);
    chk("t3_break_busy", {31'd0, busy}, 32'd1);
    chk("t3_count", n_valid, 3);
    drive_bit(1'b1, 16);
    chk("t3_no_retrigger", n_valid, 3);
    chk("t3_idle_after_break", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b0, 1'b1, 8);
    drive_bit(1'b1, 12);
    chk("t3_next_count", n_valid, 4);

    // 4: 2-clock glitch
    seen = n_valid;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 2);
    chk("t4_busy_start", {31'd0, busy}, 32'd1);
    drive_bit(1'b1, 4);  // MID+3 clocks after the line rose
    chk("t4_busy_cleared", {31'd0, busy}, 32'd0);
    drive_bit(1'b1, 100);
    chk("t4_no_valid", n_valid, seen);

    // 5: back-to-back 0x00 then 0xFF
    send_frame(8'h00, 1'b0, 1'b1, 8);
    send_frame(8'hFF, 1'b0, 1'b1, 8);
    drive_bit(1'b1, 12);
    chk("t5_count", n_valid, 6);

    // 6: reset during data bit 4 of 0x55, then clean 0x81
    d55 = 8'h55;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d55[i], 8);
    drive_bit(d55[4], 3);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("mid_reset_hold");
    rst_n = 1'b1;
    drive_bit(1'b1, 120);
    chk("t6_no_valid_55", n_valid, 6);
    send_frame(8'h81, 1'b0, 1'b1, 8);
    drive_bit(1'b1, 20);

    // drain with a bound
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    chk("valid_total", n_valid, 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
